// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : PC-owning fetch sequencer for a fixed-latency instruction memory,
//            valid/ready output to decode, branch redirect, fetch fault flag.
//            Optional fetch counter enabled by macro IMEM_FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [63:0] MEM_LIMIT   = 64'h60
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        start,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        fault,
  output logic [63:0] fault_pc
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [63:0] r_instr_pc, w_instr_pc_nxt;
  logic [63:0] r_fault_pc, w_fault_pc_nxt;

  logic [63:0] w_pc_inc;
  logic        w_redir_bad;
  logic        w_accept;

  assign w_pc_inc    = r_pc + 64'd4;
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MEM_LIMIT);
  assign w_accept    = (r_state == ST_VALID) && instr_ready;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_instr_pc <= 64'd0;
      r_fault_pc <= 64'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_fault_pc_nxt = r_fault_pc;

    case (r_state)
      ST_IDLE: begin
        // A redirect while idle only steers the PC; the first fetch needs start.
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
        if (start) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = c_wait_init;
        end
      end

      default: begin
        if (redirect) begin
          if (w_redir_bad) begin
            w_state_nxt    = ST_FAULT;
            w_fault_pc_nxt = redirect_pc;
          end else begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_wait_init;
          end
        end else begin
          case (r_state)
            ST_WAIT: begin
              if (r_cnt != 4'd0) begin
                w_cnt_nxt = r_cnt - 4'd1;
              end else begin
                w_instr_nxt    = imem_data;
                w_instr_pc_nxt = r_pc;
                w_state_nxt    = ST_VALID;
              end
            end
            ST_VALID: begin
              if (w_accept) begin
                w_pc_nxt = w_pc_inc;
                // Sequential run-off past populated memory; a wrap to low
                // addresses is legal and simply keeps fetching.
                if (w_pc_inc >= MEM_LIMIT) begin
                  w_state_nxt    = ST_FAULT;
                  w_fault_pc_nxt = w_pc_inc;
                end else begin
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = c_wait_init;
                end
              end
            end
            default: begin
              w_state_nxt = r_state;
            end
          endcase
        end
      end
    endcase
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == ST_VALID);
  assign fault       = (r_state == ST_FAULT);
  assign fault_pc    = r_fault_pc;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] r_fetch_count;

  // Counts consumed instructions, including those accepted alongside a redirect.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_fetch_count <= 32'd0;
    end else if (w_accept && (r_fetch_count != 32'hFFFF_FFFF)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and drives the processor's read-only instruction memory. It issues word addresses, waits a fixed memory read latency, and presents each instruction word with its PC to the decode stage over a valid/ready handshake. It accepts branch redirects and flags fetches that are out of range or misaligned. It sits between the PC/next-PC logic and the instruction memory, replacing the combinational PC-to-memory path.

Parameters:
WAIT_CYCLES, 2, memory read latency in clock edges beyond the first (0..15); instruction data is sampled WAIT_CYCLES+1 edges after the address is stable.
RESET_PC, 64'h0, PC loaded on reset.
MEM_LIMIT, 64'h60, first byte address outside populated instruction memory; a fetch at or above this address faults.

Ports:
CLK  input  1  system clock, rising edge.
Reset_L  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse that begins fetching from the current PC; honoured only in IDLE.
imem_addr  output  64  address to instruction memory; always equals the PC register.
imem_data  input  32  instruction word returned by memory.
instr  output  32  captured instruction word.
instr_pc  output  64  byte address of instr.
instr_valid  output  1  instr/instr_pc valid.
instr_ready  input  1  decode accepts the instruction.
redirect  input  1  load a branch target into the PC.
redirect_pc  input  64  branch target byte address.
fault  output  1  sticky fetch fault.
fault_pc  output  64  address that caused the fault.

Behaviour:
- States: IDLE, WAIT, VALID, FAULT. A 4-bit wait counter cnt and a 64-bit pc register.
- Reset (asynchronous, any state, including mid-WAIT): state=IDLE, pc=RESET_PC, cnt=0, instr=0, instr_pc=0, instr_valid=0, fault=0, fault_pc=0. imem_addr therefore equals RESET_PC.
- IDLE: start=1 moves to WAIT with cnt=WAIT_CYCLES. start is ignored in every other state. redirect in IDLE updates pc only; there is no fault check and the state stays IDLE.
- WAIT: if cnt!=0, decrement cnt. If cnt==0, latch instr=imem_data and instr_pc=pc, then move to VALID.
- Latency: instr_valid rises WAIT_CYCLES+1 edges after the edge that samples start, redirect or accept.
- VALID: instr_valid=1, and instr/instr_pc are held stable until accepted. On instr_ready=1:
  - pc<=pc+4.
  - If pc+4 >= MEM_LIMIT: go to FAULT with fault_pc=pc+4.
  - Otherwise: go to WAIT with cnt=WAIT_CYCLES.
- Throughput: one instruction per WAIT_CYCLES+2 cycles when ready is held high.
- Redirect in WAIT/VALID/FAULT has priority over the wait count and the handshake:
  - instr_valid drops on the next edge.
  - If redirect_pc[1:0]!=0 or redirect_pc >= MEM_LIMIT: go to FAULT with fault=1, fault_pc=redirect_pc, pc unchanged.
  - Otherwise: pc=redirect_pc, fault cleared, go to WAIT with cnt=WAIT_CYCLES.
- Redirect and instr_ready both high in VALID: the handshake counts as completed (the instruction is consumed), but the next pc is redirect_pc, not pc+4.
- FAULT: instr_valid=0 and fault=1. Leaving FAULT requires a valid redirect or a reset; instr_ready is ignored.
- Arithmetic: pc+4 is unsigned 64-bit and wraps modulo 2^64. A wrap below MEM_LIMIT is not a fault.
- instr is never updated outside the WAIT-to-VALID capture.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- Defined: adds output fetch_count [31:0], reset to 0.
  - Increments by one on each completed handshake in VALID, including one that coincides with a redirect.
  - Saturates at 32'hFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, pulse start, instr_ready=1, WAIT_CYCLES=2: instr_valid rises 3 edges after start. Expected sequence: instr=F84003E9/pc 0x0, then F84083EA/pc 0x4, then F84103EB/pc 0x8, spaced 4 cycles apart.
- instr_ready=0 for 10 cycles at pc 0x14: instr stays AA0B014A, instr_valid stays 1, imem_addr stays 0x14. Asserting ready then produces 8A0A018C at 0x18.
- Redirect to 0x20 in WAIT while fetching 0x28: no 0x28 instruction appears; next instr=8B0901AD/pc 0x20. Repeat with redirect and ready in the same cycle in VALID: the same instruction results, and fetch_count increments once.
- Run to pc 0x5C (instr 0xF84303EA) and accept: fault=1, fault_pc=0x60, instr_valid=0. A redirect to 0x0 clears fault and fetches F84003E9.
- Redirect to 0x22: fault=1, fault_pc=0x22, pc unchanged. Redirect to 0x64: fault=1, fault_pc=0x64.
- Assert Reset_L low mid-WAIT at pc 0x30: outputs zero immediately, imem_addr=0x0, state IDLE. No instr_valid until the next start.
